tt_um_count_checker: RTL and testbench

TT_UM_COUNT_CHECKER -- requirements
Module: tt_um_count_checker

---
 rtl/tt_um_count_checker_pkg.sv | 7 +
 rtl/count_checker_errctr.sv | 17 +
 rtl/tt_um_count_checker.sv | 85 ++++++++
 tb/tb_tt_um_count_checker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_count_checker_pkg.sv
// tt_um_count_checker_pkg: shared state encoding, counter width and default lock/loss thresholds
package tt_um_count_checker_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam int CNT_W = 4;
  localparam int LOCK_COUNT_DEF = 3;
  localparam int LOSS_COUNT_DEF = 2;
endpackage

// File: rtl/count_checker_errctr.sv
// count_checker_errctr: saturating error counter, clear beats increment
// Ports: clk, rst (async, high); i_clr sync clear; i_inc count one error; o_cnt current count
module count_checker_errctr
  import tt_um_count_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_inc && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: locks onto a +1-per-clock 4-bit count stream and counts mismatches while locked
// Ports: clk; reset (async, high); ena ignored; ui_in count stream; uio_in[0] check_en, [1] err_clr;
//        uo_out error count; uio_out[2] locked, [3] err_pulse; uio_oe fixed 4'b1100
module tt_um_count_checker
  import tt_um_count_checker_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [3:0] ui_in,
  input  logic [3:0] uio_in,
  output logic [3:0] uo_out,
  output logic [3:0] uio_out,
  output logic [3:0] uio_oe
);
  state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_prev, w_prev_n;
  logic [2:0] r_run, w_run_n, r_miss, w_miss_n;
  logic r_locked, r_err_pulse, w_err, w_match, w_en, w_unused;
  assign w_en = uio_in[0];
  assign w_match = ui_in == r_prev + CNT_W'(1);
  assign w_unused = &{ena, uio_in[3:2]};
  always_comb begin
    w_state_n = r_state;
    w_prev_n = r_prev;
    w_run_n = r_run;
    w_miss_n = r_miss;
    w_err = 1'b0;
    if (!w_en) w_state_n = IDLE;
    else begin
      // every enabled edge resynchronises to the incoming value
      w_prev_n = ui_in;
      case (r_state)
        IDLE: begin
          w_state_n = ACQUIRE;
          w_run_n = '0;
        end
        ACQUIRE: begin
          w_run_n = w_match ? r_run + 3'd1 : '0;
          if (w_match && w_run_n == 3'(LOCK_COUNT)) begin
            w_state_n = LOCKED;
            w_miss_n = '0;
          end
        end
        LOCKED: begin
          w_err = !w_match;
          w_miss_n = w_match ? '0 : r_miss + 3'd1;
          if (!w_match && w_miss_n == 3'(LOSS_COUNT)) begin
            w_state_n = ACQUIRE;
            w_run_n = '0;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_prev <= '0;
      r_run <= '0;
      r_miss <= '0;
      r_locked <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_prev <= w_prev_n;
      r_run <= w_run_n;
      r_miss <= w_miss_n;
      r_locked <= w_state_n == LOCKED;
      r_err_pulse <= w_err;
    end
  count_checker_errctr u_errctr (
    .clk  (clk),
    .rst  (reset),
    .i_clr(uio_in[1]),
    .i_inc(w_err),
    .o_cnt(uo_out)
  );
  assign uio_out = {r_err_pulse, r_locked, 2'b00};
  assign uio_oe = 4'b1100;
endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: scoreboard bench for the count checker (default instance plus LOSS_COUNT=7 instance)
module tb_tt_um_count_checker;
  localparam int LOCK = 3;
  localparam int LOSS = 2;
  logic clk = 0, reset = 1, ena = 1;
  logic [3:0] ui_in = 0, uio_in = 0;
  logic [3:0] uo_out, uio_out, uio_oe, uo_out7, uio_out7, uio_oe7;
  int errors = 0, checks = 0;
  int m_state, m_prev, m_run, m_miss, m_err;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tt_um_count_checker dut (
    .clk(clk), .reset(reset), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  tt_um_count_checker #(.LOCK_COUNT(3), .LOSS_COUNT(7)) dut7 (
    .clk(clk), .reset(reset), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out7), .uio_out(uio_out7), .uio_oe(uio_oe7)
  );

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_run = 0; m_miss = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic cycle(input logic [3:0] v, input logic en = 1'b1, input logic clr = 1'b0);
    logic match, pulse;
    logic [7:0] exp, got;
    ui_in = v;
    uio_in = {2'b00, clr, en};
    match = (int'(v) == (m_prev + 1) % 16);
    pulse = 0;
    if (!en) m_state = 0;
    else begin
      if (m_state == 0) begin
        m_state = 1; m_run = 0;
      end else if (m_state == 1) begin
        if (match) begin
          m_run++;
          if (m_run == LOCK) begin m_state = 2; m_miss = 0; end
        end else m_run = 0;
      end else begin
        if (match) m_miss = 0;
        else begin
          pulse = 1; m_miss++;
          if (m_miss == LOSS) begin m_state = 1; m_run = 0; end
        end
      end
      m_prev = int'(v);
    end
    if (clr) m_err = 0;
    else if (pulse && m_err < 15) m_err++;
    exp_q.push_back({4'(m_err), pulse, m_state == 2, 2'b00});
    @(posedge clk);
    #1;
    got = {uo_out, uio_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scoreboard t=%0t in=%0d got uo=%0d uio=%b want uo=%0d uio=%b", $time, v, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    uio_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    checks += 4;
    if (uo_out !== 4'd0) begin errors++; $display("FAIL reset_uo got %0d want 0", uo_out); end
    if (uio_out !== 4'd0) begin errors++; $display("FAIL reset_uio got %b want 0000", uio_out); end
    if (uio_oe !== 4'b1100) begin errors++; $display("FAIL reset_oe got %b want 1100", uio_oe); end
    if (uio_out7 !== 4'd0) begin errors++; $display("FAIL reset_uio7 got %b want 0000", uio_out7); end
    do_reset();
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 5; i <= 8; i++) begin
      cycle(4'(i));
      checks++;
      if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL lock_pulse in=%0d got %b want 0", i, uio_out[3]); end
      if (i == 7) begin
        checks++;
        if (uio_out[2] !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", uio_out[2]); end
      end
    end
    checks += 2;
    if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL lock_locked got %b want 1", uio_out[2]); end
    if (uo_out !== 4'd0) begin errors++; $display("FAIL lock_uo got %0d want 0", uo_out); end
  endtask

  task automatic test_wrap();
    for (int i = 9; i <= 17; i++) begin
      cycle(4'(i));
      if (i >= 14) begin
        checks += 2;
        if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL wrap_locked in=%0d got %b want 1", i % 16, uio_out[2]); end
        if (uo_out !== 4'd0) begin errors++; $display("FAIL wrap_uo in=%0d got %0d want 0", i % 16, uo_out); end
      end
    end
  endtask

  task automatic test_error_loss();
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(4'(i));
    cycle(4'd3);
    checks += 3;
    if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL err1_pulse got %b want 1", uio_out[3]); end
    if (uo_out !== 4'd1) begin errors++; $display("FAIL err1_uo got %0d want 1", uo_out); end
    if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL err1_locked got %b want 1", uio_out[2]); end
    cycle(4'd9);
    checks += 3;
    if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL err2_pulse got %b want 1", uio_out[3]); end
    if (uo_out !== 4'd2) begin errors++; $display("FAIL err2_uo got %0d want 2", uo_out); end
    if (uio_out[2] !== 1'b0) begin errors++; $display("FAIL loss_locked got %b want 0", uio_out[2]); end
    cycle(4'd10);
    checks++;
    if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", uio_out[3]); end
    cycle(4'd11);
    checks++;
    if (uio_out[2] !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", uio_out[2]); end
    cycle(4'd12);
    checks++;
    if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", uio_out[2]); end
  endtask

  task automatic test_saturation();
    logic [3:0] v;
    do_reset();
    for (int i = 0; i <= 3; i++) cycle(4'(i));
    v = 4'd3;
    for (int i = 0; i < 20; i++) begin
      if (i == 7 || i == 14) repeat (3) begin v = v + 4'd1; cycle(v); end
      v = v + 4'd2;
      cycle(v);
      if (i == 13) begin
        checks++;
        if (uo_out7 !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", uo_out7); end
      end
    end
    checks += 2;
    if (uo_out7 !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", uo_out7); end
    if (uio_out7[2] !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", uio_out7[2]); end
    v = v + 4'd2;
    cycle(v, 1'b1, 1'b1);
    checks += 2;
    if (uo_out7 !== 4'd0) begin errors++; $display("FAIL clr_uo got %0d want 0", uo_out7); end
    if (uio_out7[3] !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b want 1", uio_out7[3]); end
  endtask

  task automatic test_disable_reset();
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(4'(i));
    cycle(4'd0); cycle(4'd1); cycle(4'd5); cycle(4'd6); cycle(4'd10);
    checks++;
    if (uo_out !== 4'd3) begin errors++; $display("FAIL dis_pre_uo got %0d want 3", uo_out); end
    cycle(4'd11, 1'b0);
    cycle(4'd12, 1'b0);
    checks += 3;
    if (uio_out[2] !== 1'b0) begin errors++; $display("FAIL dis_locked got %b want 0", uio_out[2]); end
    if (uo_out !== 4'd3) begin errors++; $display("FAIL dis_uo got %0d want 3", uo_out); end
    if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL dis_pulse got %b want 0", uio_out[3]); end
    uio_in = 4'b0001;
    for (int i = 13; i <= 16; i++) cycle(4'(i));
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    checks += 3;
    if (uo_out !== 4'd0) begin errors++; $display("FAIL async_uo got %0d want 0", uo_out); end
    if (uio_out !== 4'd0) begin errors++; $display("FAIL async_uio got %b want 0000", uio_out); end
    if (uio_oe !== 4'b1100) begin errors++; $display("FAIL async_oe got %b want 1100", uio_oe); end
    do_reset();
    cycle(4'd4);
    cycle(4'd5);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_error_loss();
    test_saturation();
    test_disable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
